sic_dispatch_queue: RTL

// - Sits directly upstream of the single_instruction_controller array. Buffers renamed sic_packet_t entries from the rename/issue front end in an in-order FIFO.
// - Each cycle, hands at most one packet to one idle SIC, chosen round-robin among SICs raising req_instr.
// - Drops every queued packet on a PC-redirect flush.

---
 rtl/sic_dispatch_queue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sic_dispatch_queue.sv
// sic_dispatch_queue: in-order packet FIFO feeding a SIC array, round-robin grant.
// Optional counters stat_dispatched/stat_stall are built with DISPATCH_STATS_EN.
package sic_pkg;

  localparam int SIC_NUM_PHY_REGS = 64;
  localparam int SIC_NUM_ECRS     = 4;
  localparam int SIC_ID_WIDTH     = 8;

  typedef struct packed {
    logic                                valid;
    logic [SIC_ID_WIDTH-1:0]             id;
    logic [7:0]                          opcode;
    logic [$clog2(SIC_NUM_PHY_REGS)-1:0] pdst;
    logic [$clog2(SIC_NUM_PHY_REGS)-1:0] psrc1;
    logic [$clog2(SIC_NUM_PHY_REGS)-1:0] psrc2;
    logic [$clog2(SIC_NUM_ECRS)-1:0]     ecr;
  } sic_packet_t;

endpackage

module sic_dispatch_queue
  import sic_pkg::*;
#(
  parameter int NUM_SIC      = 4,
  parameter int NUM_PHY_REGS = SIC_NUM_PHY_REGS,
  parameter int NUM_ECRS     = SIC_NUM_ECRS,
  parameter int ID_WIDTH     = SIC_ID_WIDTH,
  parameter int DEPTH        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  sic_packet_t                 in_pkt,
  output logic                        in_ready,
  input  logic [NUM_SIC-1:0]          sic_req_instr,
  output sic_packet_t [NUM_SIC-1:0]   sic_pkt,
  input  logic                        flush,
  output logic [$clog2(DEPTH):0]      occupancy
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                 stat_dispatched,
  output logic [31:0]                 stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;

  localparam bit CFG_OK =
    (NUM_PHY_REGS == SIC_NUM_PHY_REGS) &&
    (NUM_ECRS == SIC_NUM_ECRS) &&
    (ID_WIDTH == SIC_ID_WIDTH) &&
    (DEPTH >= 2) &&
    ((DEPTH & (DEPTH - 1)) == 0);

  sic_packet_t        mem [DEPTH];
  sic_packet_t        wr_pkt;
  sic_packet_t        head;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        occ_q;
  logic [SW-1:0]      rr_ptr;
  logic [SW-1:0]      rr_next;
  logic [SW-1:0]      scan_idx;
  logic [SW-1:0]      gnt_idx;
  logic [NUM_SIC-1:0] last_grant;
  logic [NUM_SIC-1:0] elig;
  logic [NUM_SIC-1:0] gnt_oh;
  logic [NUM_SIC-1:0] pkt_valid;
  logic               gnt_found;
  logic               grant;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;

  assign full      = (occ_q == (AW + 1)'(DEPTH));
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;
  assign in_ready  = !rst && !flush && !full;
  assign push      = in_valid && in_ready;
  assign elig      = sic_req_instr & ~last_grant;
  assign grant     = gnt_found && !empty && !flush;
  assign pop       = grant;
  assign head      = mem[rd_ptr];

  always_comb begin
    wr_pkt       = in_pkt;
    wr_pkt.valid = 1'b1;
  end

  // first eligible SIC at or after rr_ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_SIC; k++) begin
      scan_idx = SW'((int'(rr_ptr) + k) % NUM_SIC);
      if (!gnt_found && elig[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (grant) gnt_oh[gnt_idx] = 1'b1;
  end

  assign rr_next = (gnt_idx == SW'(NUM_SIC - 1)) ?
                   '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_pkt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ_q      <= '0;
      rr_ptr     <= '0;
      last_grant <= '0;
      sic_pkt    <= '0;
    end else begin
      last_grant <= gnt_oh;
      for (int i = 0; i < NUM_SIC; i++) begin
        sic_pkt[i] <= gnt_oh[i] ? head : '0;
      end
      if (grant) rr_ptr <= rr_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ_q  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   occ_q <= occ_q + 1'b1;
          2'b01:   occ_q <= occ_q - 1'b1;
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dispatched <= '0;
      stat_stall      <= '0;
    end else begin
      if (grant)
        stat_dispatched <= stat_dispatched + 32'd1;
      if (!empty && !flush && !grant)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

  always_comb begin
    pkt_valid = '0;
    for (int i = 0; i < NUM_SIC; i++) begin
      pkt_valid[i] = sic_pkt[i].valid;
    end
  end

  a_cfg: assert property (@(posedge clk) CFG_OK);

  a_onehot: assert property (
    @(posedge clk) disable iff (rst)
    $onehot0(pkt_valid));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (rst)
    !(pop && empty));

endmodule
